// File: rtl/addsub_arbiter.sv
// Round-robin arbiter that shares one external add/subtract unit between two channels.
// Grant 1 cycle after req, done 1 cycle after ack, 3-cycle grant spacing; req is held until done, no aborts.
module addsub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             m0,
  input  logic             m1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res0,
  output logic [WIDTH-1:0] res1,
  output logic             ovf0,
  output logic             ovf1,
  output logic             busy,
  output logic             au_m,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  input  logic [WIDTH-1:0] au_s,
  input  logic             au_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_gnt, w_gnt_nxt;
  logic               r_last, w_last_nxt;
  logic               r_ack0, w_ack0_nxt;
  logic               r_ack1, w_ack1_nxt;
  logic               r_done0, w_done0_nxt;
  logic               r_done1, w_done1_nxt;
  logic [WIDTH-1:0]   r_res0, w_res0_nxt;
  logic [WIDTH-1:0]   r_res1, w_res1_nxt;
  logic               r_ovf0, w_ovf0_nxt;
  logic               r_ovf1, w_ovf1_nxt;
  logic               r_au_m, w_au_m_nxt;
  logic [WIDTH-1:0]   r_au_a, w_au_a_nxt;
  logic [WIDTH-1:0]   r_au_b, w_au_b_nxt;
  logic               w_pick;

  // On a tie the channel opposite the last-served one wins; otherwise the lone requester.
  assign w_pick = (req0 && req1) ? ~r_last : req1;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_done0_nxt = 1'b0;
    w_done1_nxt = 1'b0;
    w_res0_nxt  = r_res0;
    w_res1_nxt  = r_res1;
    w_ovf0_nxt  = r_ovf0;
    w_ovf1_nxt  = r_ovf1;
    w_au_m_nxt  = r_au_m;
    w_au_a_nxt  = r_au_a;
    w_au_b_nxt  = r_au_b;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_gnt_nxt   = w_pick;
          w_last_nxt  = w_pick;
          w_au_m_nxt  = w_pick ? m1 : m0;
          w_au_a_nxt  = w_pick ? a1 : a0;
          w_au_b_nxt  = w_pick ? b1 : b0;
          w_ack0_nxt  = ~w_pick;
          w_ack1_nxt  = w_pick;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (r_gnt) begin
          w_res1_nxt  = au_s;
          w_ovf1_nxt  = au_ovf;
          w_done1_nxt = 1'b1;
        end else begin
          w_res0_nxt  = au_s;
          w_ovf0_nxt  = au_ovf;
          w_done0_nxt = 1'b1;
        end
        w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_res0  <= '0;
      r_res1  <= '0;
      r_ovf0  <= 1'b0;
      r_ovf1  <= 1'b0;
      r_au_m  <= 1'b0;
      r_au_a  <= '0;
      r_au_b  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
      r_res0  <= w_res0_nxt;
      r_res1  <= w_res1_nxt;
      r_ovf0  <= w_ovf0_nxt;
      r_ovf1  <= w_ovf1_nxt;
      r_au_m  <= w_au_m_nxt;
      r_au_a  <= w_au_a_nxt;
      r_au_b  <= w_au_b_nxt;
    end
  end

  assign ack0  = r_ack0;
  assign ack1  = r_ack1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign res0  = r_res0;
  assign res1  = r_res1;
  assign ovf0  = r_ovf0;
  assign ovf1  = r_ovf1;
  assign busy  = (r_state != IDLE);
  assign au_m  = r_au_m;
  assign au_a  = r_au_a;
  assign au_b  = r_au_b;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a behavioural model of the shared add/subtract unit.
module tb_addsub_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, m0, m1;
  logic [7:0] a0, b0, a1, b1;
  logic       ack0, ack1, done0, done1, ovf0, ovf1, busy, au_m, au_ovf;
  logic [7:0] res0, res1, au_a, au_b, au_s;
  int         checks = 0;
  int         errors = 0;

  addsub_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .m0(m0), .m1(m1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .res0(res0), .res1(res1), .ovf0(ovf0), .ovf1(ovf1),
    .busy(busy), .au_m(au_m), .au_a(au_a), .au_b(au_b),
    .au_s(au_s), .au_ovf(au_ovf)
  );

  always #5 clk = ~clk;

  // Shared unit lives outside the DUT: combinational add/sub with signed overflow.
  assign au_s   = au_m ? (au_a - au_b) : (au_a + au_b);
  assign au_ovf = au_m ? ((au_a[7] != au_b[7]) && (au_s[7] != au_a[7]))
                       : ((au_a[7] == au_b[7]) && (au_s[7] != au_a[7]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input bit ch, input bit m, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input bit eo,
                        input logic [7:0] ores, input bit oovf);
    if (ch) begin req1 = 1'b1; m1 = m; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; m0 = m; a0 = a; b0 = b; end
    tick();
    chk("single_ack", {30'd0, ack1, ack0}, ch ? 32'd2 : 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_au", {23'd0, au_m, au_a, au_b}, {23'd0, m, a, b});
    tick();
    chk("single_done", {30'd0, done1, done0}, ch ? 32'd2 : 32'd1);
    chk("single_res", {23'd0, ch ? ovf1 : ovf0, ch ? res1 : res0}, {23'd0, eo, er});
    chk("single_other", {23'd0, ch ? ovf0 : ovf1, ch ? res0 : res1}, {23'd0, oovf, ores});
    if (ch) req1 = 1'b0; else req0 = 1'b0;
    tick();
    chk("single_end", {29'd0, busy, done1, done0}, 32'd0);
  endtask

  logic [7:0] t_a0 [2], t_b0 [2], t_a1 [2], t_b1 [2], t_r0 [2], t_r1 [2];
  bit         t_m0 [2], t_m1 [2], t_o0 [2], t_o1 [2];

  initial begin
    t_a0[0] = 8'hFF; t_b0[0] = 8'h01; t_m0[0] = 0; t_r0[0] = 8'h00; t_o0[0] = 0;
    t_a1[0] = 8'hFF; t_b1[0] = 8'hFF; t_m1[0] = 0; t_r1[0] = 8'hFE; t_o1[0] = 0;
    t_a0[1] = 8'h10; t_b0[1] = 8'h20; t_m0[1] = 0; t_r0[1] = 8'h30; t_o0[1] = 0;
    t_a1[1] = 8'h05; t_b1[1] = 8'h10; t_m1[1] = 1; t_r1[1] = 8'hF5; t_o1[1] = 0;

    rst = 1'b1; req0 = 0; req1 = 0; m0 = 0; m1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    #1;
    chk("rst_ctrl", {26'd0, busy, ack1, ack0, done1, done0, au_m}, 32'd0);
    chk("rst_data", {14'd0, ovf1, ovf0, res1, res0}, 32'd0);
    chk("rst_au", {16'd0, au_a, au_b}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;

    // Reset asserted mid-EXEC aborts the transaction.
    req0 = 1'b1; m0 = 0; a0 = 8'h7F; b0 = 8'h01;
    tick();
    chk("abort_ack", {30'd0, ack1, ack0}, 32'd1);
    chk("abort_au", {16'd0, au_a, au_b}, 32'h7F01);
    #2 rst = 1'b1;
    #1;
    chk("abort_clear", {26'd0, busy, ack1, ack0, done1, done0, au_m}, 32'd0);
    chk("abort_data", {16'd0, au_a, res0}, 32'd0);
    req0 = 1'b0;
    tick();
    tick();
    chk("abort_nodone", {29'd0, busy, done1, done0}, 32'd0);
    rst = 1'b0;
    tick();

    // Contention: first tie after reset goes to ch0, then alternates.
    for (int r = 0; r < 2; r++) begin
      req0 = 1; m0 = t_m0[r]; a0 = t_a0[r]; b0 = t_b0[r];
      req1 = 1; m1 = t_m1[r]; a1 = t_a1[r]; b1 = t_b1[r];
      tick();
      chk("rr_ack0", {30'd0, ack1, ack0}, 32'd1);
      tick();
      chk("rr_done0", {30'd0, done1, done0}, 32'd1);
      chk("rr_res0", {23'd0, ovf0, res0}, {23'd0, t_o0[r], t_r0[r]});
      req0 = 0;
      tick();
      chk("rr_gap", {28'd0, busy, ack1, done1, done0}, 32'd0);
      tick();
      chk("rr_ack1", {30'd0, ack1, ack0}, 32'd2);
      tick();
      chk("rr_done1", {30'd0, done1, done0}, 32'd2);
      chk("rr_res1", {23'd0, ovf1, res1}, {23'd0, t_o1[r], t_r1[r]});
      chk("rr_keep0", {23'd0, ovf0, res0}, {23'd0, t_o0[r], t_r0[r]});
      req1 = 0;
      tick();
      chk("rr_idle", {31'd0, busy}, 32'd0);
    end

    single(1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b1, 8'hF5, 1'b0);
    single(1'b1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 8'h80, 1'b1);
    single(1'b1, 1'b1, 8'h6C, 8'hCA, 8'hA2, 1'b1, 8'h80, 1'b1);

    // Operands and req change right after ack; latched values are used.
    req0 = 1; m0 = 0; a0 = 8'h55; b0 = 8'hAA;
    tick();
    chk("hold_ack", {30'd0, ack1, ack0}, 32'd1);
    a0 = 8'h00; req0 = 0;
    tick();
    chk("hold_done", {30'd0, done1, done0}, 32'd1);
    chk("hold_res", {23'd0, ovf0, res0}, {23'd0, 1'b0, 8'hFF});
    chk("hold_au", {16'd0, au_a, au_b}, 32'h55AA);
    tick();
    chk("hold_once", {30'd0, done1, done0}, 32'd0);

    // Idle stability.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_quiet", {27'd0, busy, ack1, ack0, done1, done0}, 32'd0);
    end
    chk("idle_res", {14'd0, ovf1, ovf0, res1, res0}, {14'd0, 1'b1, 1'b0, 8'hA2, 8'hFF});
    chk("idle_au", {15'd0, au_m, au_a, au_b}, {15'd0, 1'b0, 8'h55, 8'hAA});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
